// File: rtl/ga_pkg.sv
// ============================================================================
// Module      : ga_pkg
// Description : Shared constants, data types and scan FSM states for the
//               GA parent-selection stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ga_pkg;

    localparam int POP_SIZE = 50;
    localparam int DIST_W   = 12;
    localparam int GENOME_W = 150;
    localparam int IDX_W    = 6;

    typedef logic [DIST_W-1:0]   dist_t;
    typedef logic [GENOME_W-1:0] genome_t;
    typedef logic [IDX_W-1:0]    idx_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_SCAN   = 2'd2,
        S_FINISH = 2'd3
    } sel_state_t;

endpackage

`default_nettype wire

// File: rtl/top2_tracker.sv
// ============================================================================
// Module      : top2_tracker
// Description : Combinational update of a (best, second) shortest-distance
//               pair for one incoming candidate.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module top2_tracker #(
    parameter int DIST_W = ga_pkg::DIST_W,
    parameter int IDX_W  = ga_pkg::IDX_W
) (
    input  logic [IDX_W-1:0]  best_idx,
    input  logic [DIST_W-1:0] best_dist,
    input  logic [IDX_W-1:0]  second_idx,
    input  logic [DIST_W-1:0] second_dist,
    input  logic [IDX_W-1:0]  cand_idx,
    input  logic [DIST_W-1:0] cand_dist,
    output logic [IDX_W-1:0]  new_best_idx,
    output logic [DIST_W-1:0] new_best_dist,
    output logic [IDX_W-1:0]  new_second_idx,
    output logic [DIST_W-1:0] new_second_dist
);

    // Strict compares: on a tie the earlier (lower) index keeps its place.
    always_comb begin
        new_best_idx    = best_idx;
        new_best_dist   = best_dist;
        new_second_idx  = second_idx;
        new_second_dist = second_dist;
        if (cand_dist < best_dist) begin
            new_second_idx  = best_idx;
            new_second_dist = best_dist;
            new_best_idx    = cand_idx;
            new_best_dist   = cand_dist;
        end else if (cand_dist < second_dist) begin
            new_second_idx  = cand_idx;
            new_second_dist = cand_dist;
        end
    end

endmodule

`default_nettype wire

// File: rtl/parent_select_scan.sv
// ============================================================================
// Module      : parent_select_scan
// Description : Snapshots a scored population and scans it for the two
//               shortest tours, presenting them as crossover parents.
//               Optional macro PARENT_SELECT_BEST_EVER_EN adds a best-ever
//               distance/genome record.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module parent_select_scan #(
    parameter int POP_SIZE = ga_pkg::POP_SIZE,
    parameter int DIST_W   = ga_pkg::DIST_W,
    parameter int GENOME_W = ga_pkg::GENOME_W,
    parameter int IDX_W    = ga_pkg::IDX_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         dist_done,
    input  logic [POP_SIZE*DIST_W-1:0]   distances,
    input  logic [POP_SIZE*GENOME_W-1:0] pop,
    output logic                         busy,
    output logic                         sel_done,
    output logic                         sel_valid,
    output logic [IDX_W-1:0]             best_idx,
    output logic [IDX_W-1:0]             second_idx,
    output logic [DIST_W-1:0]            best_dist,
    output logic [DIST_W-1:0]            second_dist,
    output logic [GENOME_W-1:0]          parent_a,
    output logic [GENOME_W-1:0]          parent_b
`ifdef PARENT_SELECT_BEST_EVER_EN
    ,
    output logic [DIST_W-1:0]            best_ever_dist,
    output logic [GENOME_W-1:0]          best_ever_genome
`endif
);

    import ga_pkg::*;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(POP_SIZE - 1);

    sel_state_t                   state;
    logic                         dist_done_q;
    logic [POP_SIZE*DIST_W-1:0]   snap_dist;
    logic [POP_SIZE*GENOME_W-1:0] snap_pop;
    logic [IDX_W-1:0]             scan_idx;
    logic [IDX_W-1:0]             cur_best_idx, cur_second_idx;
    logic [DIST_W-1:0]            cur_best_dist, cur_second_dist;

    logic                         trigger;
    logic [DIST_W-1:0]            seed_d0, seed_d1, cand_dist;
    logic [IDX_W-1:0]             trk_best_idx, trk_second_idx;
    logic [DIST_W-1:0]            trk_best_dist, trk_second_dist;

    assign trigger   = dist_done & ~dist_done_q;
    assign seed_d0   = snap_dist[0 +: DIST_W];
    assign seed_d1   = snap_dist[DIST_W +: DIST_W];
    assign cand_dist = snap_dist[scan_idx*DIST_W +: DIST_W];

    top2_tracker #(
        .DIST_W (DIST_W),
        .IDX_W  (IDX_W)
    ) u_tracker (
        .best_idx        (cur_best_idx),
        .best_dist       (cur_best_dist),
        .second_idx      (cur_second_idx),
        .second_dist     (cur_second_dist),
        .cand_idx        (scan_idx),
        .cand_dist       (cand_dist),
        .new_best_idx    (trk_best_idx),
        .new_best_dist   (trk_best_dist),
        .new_second_idx  (trk_second_idx),
        .new_second_dist (trk_second_dist)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            dist_done_q      <= 1'b0;
            snap_dist        <= '0;
            snap_pop         <= '0;
            scan_idx         <= '0;
            cur_best_idx     <= '0;
            cur_second_idx   <= '0;
            cur_best_dist    <= '0;
            cur_second_dist  <= '0;
            busy             <= 1'b0;
            sel_done         <= 1'b0;
            sel_valid        <= 1'b0;
            best_idx         <= '0;
            second_idx       <= '0;
            best_dist        <= '0;
            second_dist      <= '0;
            parent_a         <= '0;
            parent_b         <= '0;
`ifdef PARENT_SELECT_BEST_EVER_EN
            best_ever_dist   <= '1;
            best_ever_genome <= '0;
`endif
        end else begin
            dist_done_q <= dist_done;
            sel_done    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (trigger) begin
                        snap_dist <= distances;
                        snap_pop  <= pop;
                        busy      <= 1'b1;
                        state     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (seed_d1 < seed_d0) begin
                        cur_best_idx    <= IDX_W'(1);
                        cur_best_dist   <= seed_d1;
                        cur_second_idx  <= IDX_W'(0);
                        cur_second_dist <= seed_d0;
                    end else begin
                        cur_best_idx    <= IDX_W'(0);
                        cur_best_dist   <= seed_d0;
                        cur_second_idx  <= IDX_W'(1);
                        cur_second_dist <= seed_d1;
                    end
                    scan_idx <= IDX_W'(2);
                    state    <= (POP_SIZE > 2) ? S_SCAN : S_FINISH;
                end
                S_SCAN: begin
                    cur_best_idx    <= trk_best_idx;
                    cur_best_dist   <= trk_best_dist;
                    cur_second_idx  <= trk_second_idx;
                    cur_second_dist <= trk_second_dist;
                    if (scan_idx == LAST_IDX) begin
                        state <= S_FINISH;
                    end else begin
                        scan_idx <= scan_idx + IDX_W'(1);
                    end
                end
                S_FINISH: begin
                    best_idx    <= cur_best_idx;
                    second_idx  <= cur_second_idx;
                    best_dist   <= cur_best_dist;
                    second_dist <= cur_second_dist;
                    parent_a    <= snap_pop[cur_best_idx*GENOME_W +: GENOME_W];
                    parent_b    <= snap_pop[cur_second_idx*GENOME_W +: GENOME_W];
                    sel_done    <= 1'b1;
                    sel_valid   <= 1'b1;
                    busy        <= 1'b0;
                    state       <= S_IDLE;
`ifdef PARENT_SELECT_BEST_EVER_EN
                    // Equal distance keeps the older genome.
                    if (cur_best_dist < best_ever_dist) begin
                        best_ever_dist   <= cur_best_dist;
                        best_ever_genome <= snap_pop[cur_best_idx*GENOME_W +: GENOME_W];
                    end
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_parent_select_scan.sv
// ============================================================================
// Module      : tb_parent_select_scan
// Description : Self-checking bench for parent_select_scan with a reference
//               model of the two-shortest selection and its timing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_parent_select_scan;

    import ga_pkg::*;

    localparam int P  = POP_SIZE;
    localparam int DW = DIST_W;
    localparam int GW = GENOME_W;
    localparam int IW = IDX_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              dist_done = 1'b0;
    logic [P*DW-1:0]   distances = '0;
    logic [P*GW-1:0]   pop = '0;
    logic              busy, sel_done, sel_valid;
    logic [IW-1:0]     best_idx, second_idx;
    logic [DW-1:0]     best_dist, second_dist;
    logic [GW-1:0]     parent_a, parent_b;
`ifdef PARENT_SELECT_BEST_EVER_EN
    logic [DW-1:0]     best_ever_dist;
    logic [GW-1:0]     best_ever_genome;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    parent_select_scan dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dist_done   (dist_done),
        .distances   (distances),
        .pop         (pop),
        .busy        (busy),
        .sel_done    (sel_done),
        .sel_valid   (sel_valid),
        .best_idx    (best_idx),
        .second_idx  (second_idx),
        .best_dist   (best_dist),
        .second_dist (second_dist),
        .parent_a    (parent_a),
        .parent_b    (parent_b)
`ifdef PARENT_SELECT_BEST_EVER_EN
        ,
        .best_ever_dist   (best_ever_dist),
        .best_ever_genome (best_ever_genome)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [GW-1:0] gval(input int i, input int seed);
        logic [159:0] t;
        t = {5{(i * 32'h9E3779B1) ^ seed}};
        return t[GW-1:0];
    endfunction

    // ---------------- reference model ----------------
    logic          m_busy = 1'b0, m_prev = 1'b0;
    int            m_left = 0;
    logic          e_done = 1'b0, e_valid = 1'b0;
    logic [IW-1:0] e_bi = '0, e_si = '0, p_bi, p_si;
    logic [DW-1:0] e_bd = '0, e_sd = '0, p_bd, p_sd;
    logic [GW-1:0] e_a = '0, e_b = '0, p_a, p_b;
    logic [DW-1:0] e_be_d = '1;
    logic [GW-1:0] e_be_g = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_prev = 0; m_left = 0;
            e_done = 0; e_valid = 0;
            e_bi = '0; e_si = '0; e_bd = '0; e_sd = '0; e_a = '0; e_b = '0;
            e_be_d = '1; e_be_g = '0;
        end else begin
            e_done = 0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    e_bi = p_bi; e_si = p_si; e_bd = p_bd; e_sd = p_sd;
                    e_a = p_a; e_b = p_b;
                    e_done = 1; e_valid = 1; m_busy = 0;
                    if (p_bd < e_be_d) begin
                        e_be_d = p_bd;
                        e_be_g = p_a;
                    end
                end
            end else if (dist_done && !m_prev) begin
                // Minimum at lowest index, then minimum of the rest at lowest index.
                int bi, si;
                bi = 0;
                for (int i = 1; i < P; i++)
                    if (distances[i*DW +: DW] < distances[bi*DW +: DW]) bi = i;
                si = (bi == 0) ? 1 : 0;
                for (int i = 0; i < P; i++)
                    if (i != bi && distances[i*DW +: DW] < distances[si*DW +: DW]) si = i;
                p_bi = IW'(bi); p_si = IW'(si);
                p_bd = distances[bi*DW +: DW]; p_sd = distances[si*DW +: DW];
                p_a = pop[bi*GW +: GW]; p_b = pop[si*GW +: GW];
                m_busy = 1; m_left = P;
            end
            m_prev = dist_done;
        end
    end

    always @(negedge clk) begin
        chk("busy", 160'(busy), 160'(m_busy));
        chk("sel_done", 160'(sel_done), 160'(e_done));
        chk("sel_valid", 160'(sel_valid), 160'(e_valid));
        chk("best_idx", 160'(best_idx), 160'(e_bi));
        chk("second_idx", 160'(second_idx), 160'(e_si));
        chk("best_dist", 160'(best_dist), 160'(e_bd));
        chk("second_dist", 160'(second_dist), 160'(e_sd));
        chk("parent_a", 160'(parent_a), 160'(e_a));
        chk("parent_b", 160'(parent_b), 160'(e_b));
        chk("idx_distinct", 160'(best_idx != second_idx || !sel_valid), 160'(1));
`ifdef PARENT_SELECT_BEST_EVER_EN
        chk("best_ever_dist", 160'(best_ever_dist), 160'(e_be_d));
        chk("best_ever_genome", 160'(best_ever_genome), 160'(e_be_g));
`endif
    end

    // ---------------- stimulus helpers ----------------
    task automatic fill(input int base, input int seed);
        for (int i = 0; i < P; i++) begin
            distances[i*DW +: DW] = DW'(base);
            pop[i*GW +: GW] = gval(i, seed);
        end
    endtask

    task automatic set_d(input int i, input int v);
        distances[i*DW +: DW] = DW'(v);
    endtask

    // Pulse dist_done for one cycle; optionally re-pulse at retrig; return
    // the number of cycles until sel_done is seen.
    task automatic run_scan(input int retrig, output int lat);
        lat = -1;
        @(negedge clk); #1 dist_done = 1'b1;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (sel_done) begin
                lat = n;
                break;
            end
            #1;
            if (n == retrig) begin
                chk("busy_at_retrigger", 160'(busy), 160'(1));
                dist_done = 1'b1;
            end else begin
                dist_done = 1'b0;
            end
        end
        if (lat < 0) begin
            n_checks++; n_fail++;
            $display("FAIL scan_timeout: got no sel_done expected one within 200 cycles");
        end
        #1 dist_done = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, pulses;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst busy", 160'(busy), 160'(0));
        chk("rst sel_valid", 160'(sel_valid), 160'(0));
        chk("rst parent_a", 160'(parent_a), 160'(0));
`ifdef PARENT_SELECT_BEST_EVER_EN
        chk("rst best_ever_dist", 160'(best_ever_dist), 160'(12'hFFF));
`endif
        #1 rst_n = 1'b1;

        // 1: distinct distances, two planted minima
        fill(0, 32'h1234_5678);
        for (int i = 0; i < P; i++) set_d(i, 100 + i);
        set_d(37, 5); set_d(12, 7);
        run_scan(0, lat);
        chk("t1 latency", 160'(lat), 160'(51));
        chk("t1 best_idx", 160'(best_idx), 160'(37));
        chk("t1 best_dist", 160'(best_dist), 160'(5));
        chk("t1 second_idx", 160'(second_idx), 160'(12));
        chk("t1 second_dist", 160'(second_dist), 160'(7));
        chk("t1 parent_a", 160'(parent_a), 160'(gval(37, 32'h1234_5678)));
        chk("t1 parent_b", 160'(parent_b), 160'(gval(12, 32'h1234_5678)));
        // Inputs changed afterwards must not disturb the held result
        fill(1, 99);
        repeat (5) @(negedge clk);
        chk("t1 hold best_idx", 160'(best_idx), 160'(37));

        // 2: all-ones distances
        fill(12'hFFF, 2);
        run_scan(0, lat);
        chk("t2 best_idx", 160'(best_idx), 160'(0));
        chk("t2 second_idx", 160'(second_idx), 160'(1));
        chk("t2 best_dist", 160'(best_dist), 160'(12'hFFF));
        chk("t2 second_dist", 160'(second_dist), 160'(12'hFFF));

        // 3: seed swap plus tie at the last index
        fill(500, 3);
        set_d(0, 9); set_d(1, 3); set_d(49, 3);
        run_scan(0, lat);
        chk("t3 best_idx", 160'(best_idx), 160'(1));
        chk("t3 second_idx", 160'(second_idx), 160'(49));
        chk("t3 best_dist", 160'(best_dist), 160'(3));
        chk("t3 parent_b", 160'(parent_b), 160'(gval(49, 3)));

        // 4: retrigger during scan is ignored
        fill(300, 4);
        set_d(20, 10); set_d(30, 11);
        run_scan(11, lat);
        chk("t4 latency", 160'(lat), 160'(51));
        pulses = 0;
        repeat (60) begin
            @(negedge clk);
            if (sel_done) pulses++;
        end
        chk("t4 extra sel_done pulses", 160'(pulses), 160'(0));
        chk("t4 best_idx", 160'(best_idx), 160'(20));

        // 5: reset mid-scan, then a clean rerun
        fill(0, 32'h1234_5678);
        for (int i = 0; i < P; i++) set_d(i, 100 + i);
        set_d(37, 5); set_d(12, 7);
        @(negedge clk); #1 dist_done = 1'b1;
        @(negedge clk); #1 dist_done = 1'b0;
        repeat (20) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("t5 rst busy", 160'(busy), 160'(0));
        chk("t5 rst sel_valid", 160'(sel_valid), 160'(0));
        chk("t5 rst best_idx", 160'(best_idx), 160'(0));
        chk("t5 rst parent_a", 160'(parent_a), 160'(0));
        @(negedge clk); #1 rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("t5 no stale sel_valid", 160'(sel_valid), 160'(0));
        run_scan(0, lat);
        chk("t5 latency", 160'(lat), 160'(51));
        chk("t5 best_idx", 160'(best_idx), 160'(37));
        chk("t5 second_idx", 160'(second_idx), 160'(12));

`ifdef PARENT_SELECT_BEST_EVER_EN
        // 6: best-ever record keeps the better older generation
        @(negedge clk); #1 rst_n = 1'b0;
        @(negedge clk); #1 rst_n = 1'b1;
        fill(500, 7); set_d(5, 40);
        run_scan(0, lat);
        fill(500, 8); set_d(9, 60);
        run_scan(0, lat);
        chk("t6 best_dist gen2", 160'(best_dist), 160'(60));
        chk("t6 best_ever_dist", 160'(best_ever_dist), 160'(40));
        chk("t6 best_ever_genome", 160'(best_ever_genome), 160'(gval(5, 7)));
`endif

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
